serial_subtractor: RTL and testbench

//   Bit-serial, parametrised WIDTH-bit subtractor: diff = a - b - bin.
//   It processes one bit per clock, LSB first.

---
 rtl/serial_subtractor_if.sv | 36 +++
 rtl/serial_subtractor.sv | 138 +++++++++++++
 tb/tb_serial_subtractor.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Start/done handshake and operand/result bundle for serial_subtractor.
//   master : requester side, drives start/a/b/bin and observes the result
//   slave  : subtractor side, drives busy/done/diff/borr/ovf
//   Signals:
//     start  request, honoured only while busy is low
//     a, b   minuend / subtrahend (WIDTH bits)
//     bin    borrow-in
//     busy   subtraction in progress
//     done   one-cycle pulse, diff/borr/ovf valid
//     diff   a - b - bin modulo 2^WIDTH
//     borr   final borrow-out
//     ovf    signed two's-complement overflow
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borr;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, borr, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, borr, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor computing diff = a - b - bin, one bit per
//   clock, LSB first, using a single full-subtractor cell and a registered
//   borrow. The result registers only change when a subtraction completes,
//   so partial results never appear on diff.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous reset, active-high, priority over everything else
//     bus  serial_subtractor_if.slave (start/a/b/bin in, busy/done/diff/borr/ovf out)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; last result held on diff/borr/ovf
//   RUN   | one operand bit per clock, busy high, start ignored
//   DONE  | single-cycle done pulse; start here begins the next operation
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic             br;
  logic             br_nxt;
  logic             d_bit;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;

  logic [WIDTH-1:0] diff_q;
  logic             borr_q;
  logic             ovf_q;
  logic             ovf_nxt;

  // Full-subtractor cell on the current LSB of the operand shift registers.
  always_comb begin
    d_bit   = a_sh[0] ^ b_sh[0] ^ br;
    br_nxt  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    res_nxt = res_sh >> 1;
    res_nxt[WIDTH-1] = d_bit;
    last_bit = (cnt == CNT_LAST);
    // On the final bit the shift registers hold the operand MSBs at bit 0,
    // and d_bit is the result MSB, so overflow needs no extra capture regs.
    ovf_nxt = (a_sh[0] != b_sh[0]) && (d_bit != a_sh[0]);
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      borr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_sh <= bus.a;
      b_sh <= bus.b;
      br   <= bus.bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      br     <= br_nxt;
      res_sh <= res_nxt;
      // The counter stops being meaningful after the last bit; it is
      // reloaded on the next accepted start, so its wrap is harmless.
      cnt    <= cnt + CNT_W'(1);
      if (last_bit) begin
        diff_q <= res_nxt;
        borr_q <= br_nxt;
        ovf_q  <= ovf_nxt;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.borr = borr_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Drives three serial_subtractor instances (WIDTH 1, 8, 13) and compares
//   them with a plain-arithmetic reference: {borr,diff} = a - b - bin.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst8, rst13;

  serial_subtractor_if #(.WIDTH(1))  if1 ();
  serial_subtractor_if #(.WIDTH(8))  if8 ();
  serial_subtractor_if #(.WIDTH(13)) if13 ();

  serial_subtractor #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst1),  .bus(if1.slave));
  serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst8),  .bus(if8.slave));
  serial_subtractor #(.WIDTH(13)) dut13 (.clk(clk), .rst(rst13), .bus(if13.slave));

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] last_diff [3];
  logic        last_borr [3];
  logic        last_ovf  [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int idx(input int w);
    return (w == 1) ? 0 : (w == 8) ? 1 : 2;
  endfunction

  task automatic drive(input int w, input logic st, input logic [15:0] a,
                       input logic [15:0] b, input logic bi);
    case (w)
      1: begin
        if1.start = st; if1.a = a[0:0]; if1.b = b[0:0]; if1.bin = bi;
      end
      8: begin
        if8.start = st; if8.a = a[7:0]; if8.b = b[7:0]; if8.bin = bi;
      end
      default: begin
        if13.start = st; if13.a = a[12:0]; if13.b = b[12:0]; if13.bin = bi;
      end
    endcase
  endtask

  task automatic sample(input int w, output logic [15:0] diff, output logic borr,
                        output logic ovf, output logic busy, output logic done);
    diff = '0;
    case (w)
      1: begin
        diff[0:0] = if1.diff; borr = if1.borr; ovf = if1.ovf;
        busy = if1.busy; done = if1.done;
      end
      8: begin
        diff[7:0] = if8.diff; borr = if8.borr; ovf = if8.ovf;
        busy = if8.busy; done = if8.done;
      end
      default: begin
        diff[12:0] = if13.diff; borr = if13.borr; ovf = if13.ovf;
        busy = if13.busy; done = if13.done;
      end
    endcase
  endtask

  // Reference: unsigned subtraction one bit wider than the operands; the
  // extra bit is the borrow-out.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic bi, output logic [15:0] d, output logic br,
                       output logic ov);
    logic [16:0] full;
    logic [15:0] mask;
    logic [15:0] am, bm;
    mask = 16'((17'h1 << w) - 17'h1);
    am   = a & mask;
    bm   = b & mask;
    full = {1'b0, am} - {1'b0, bm} - 17'(bi);
    d    = full[15:0] & mask;
    br   = full[w];
    ov   = (am[w-1] != bm[w-1]) && (d[w-1] != am[w-1]);
  endtask

  // Starts an operation at the current negedge, scrambles the inputs after
  // acceptance, optionally pokes start mid-RUN, and returns at the negedge
  // where done is seen (state DONE) so a caller can chain a new start.
  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic bi, input bit poke, input string tag);
    logic [15:0] ed, d;
    logic        eb, eo, br, ov, bs, dn;
    int          edges;
    int          k;
    k = idx(w);
    model(w, a, b, bi, ed, eb, eo);
    drive(w, 1'b1, a, b, bi);
    @(negedge clk);
    edges = 0;
    drive(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    sample(w, d, br, ov, bs, dn);
    chk({tag, "/busy"}, 32'(bs), 32'd1);
    dn = 1'b0;
    while (edges < w + 4) begin
      sample(w, d, br, ov, bs, dn);
      if (dn) break;
      chk({tag, "/hold_diff"}, 32'(d), 32'(last_diff[k]));
      chk({tag, "/hold_borr"}, 32'(br), 32'(last_borr[k]));
      if (poke && edges == 2) begin
        drive(w, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
      end else if (poke && edges == 3) begin
        drive(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
      end
      @(negedge clk);
      edges++;
    end
    chk({tag, "/latency"}, 32'(edges), 32'(w));
    chk({tag, "/diff"}, 32'(d), 32'(ed));
    chk({tag, "/borr"}, 32'(br), 32'(eb));
    chk({tag, "/ovf"}, 32'(ov), 32'(eo));
    last_diff[k] = ed;
    last_borr[k] = eb;
    last_ovf[k]  = eo;
  endtask

  // One cycle after done: pulse is over, unit idle, result still held.
  task automatic done_low(input int w, input string tag);
    logic [15:0] d;
    logic        br, ov, bs, dn;
    @(negedge clk);
    sample(w, d, br, ov, bs, dn);
    chk({tag, "/done_pulse"}, 32'(dn), 32'd0);
    chk({tag, "/idle_busy"}, 32'(bs), 32'd0);
    chk({tag, "/idle_diff"}, 32'(d), 32'(last_diff[idx(w)]));
    chk({tag, "/idle_ovf"}, 32'(ov), 32'(last_ovf[idx(w)]));
  endtask

  task automatic check_zero(input int w, input string tag);
    logic [15:0] d;
    logic        br, ov, bs, dn;
    sample(w, d, br, ov, bs, dn);
    chk({tag, "/busy"}, 32'(bs), 32'd0);
    chk({tag, "/done"}, 32'(dn), 32'd0);
    chk({tag, "/diff"}, 32'(d), 32'd0);
    chk({tag, "/borr"}, 32'(br), 32'd0);
    chk({tag, "/ovf"}, 32'(ov), 32'd0);
  endtask

  initial begin
    logic [15:0] d;
    logic        br, ov, bs, dn;
    logic [15:0] ra, rb;

    for (int i = 0; i < 3; i++) begin
      last_diff[i] = '0;
      last_borr[i] = 1'b0;
      last_ovf[i]  = 1'b0;
    end
    rst1 = 1'b1; rst8 = 1'b1; rst13 = 1'b1;
    drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(13, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (3) @(negedge clk);
    check_zero(1, "rst_w1");
    check_zero(8, "rst_w8");
    check_zero(13, "rst_w13");
    rst1 = 1'b0; rst8 = 1'b0; rst13 = 1'b0;
    @(negedge clk);

    // WIDTH=1 half-subtractor truth table
    for (int i = 0; i < 4; i++) begin
      ra = 16'(i >> 1);
      rb = 16'(i & 1);
      run_op(1, ra, rb, 1'b0, 1'b0, "w1_tt");
      done_low(1, "w1_tt");
    end

    // Directed WIDTH=8 cases
    run_op(8, 16'h35, 16'h12, 1'b0, 1'b0, "w8_35_12");
    done_low(8, "w8_35_12");
    run_op(8, 16'h00, 16'h01, 1'b0, 1'b0, "w8_wrap");
    done_low(8, "w8_wrap");
    run_op(8, 16'h10, 16'h10, 1'b1, 1'b0, "w8_bin");
    done_low(8, "w8_bin");
    run_op(8, 16'h80, 16'h01, 1'b0, 1'b0, "w8_ovf_neg");
    done_low(8, "w8_ovf_neg");
    run_op(8, 16'h7F, 16'hFF, 1'b0, 1'b0, "w8_ovf_pos");
    done_low(8, "w8_ovf_pos");

    // Handshake: mid-RUN start ignored, back-to-back start taken in DONE
    run_op(8, 16'h35, 16'h12, 1'b0, 1'b1, "w8_poke");
    run_op(8, 16'hA5, 16'h5A, 1'b1, 1'b1, "w8_b2b");
    run_op(13, 16'h1234, 16'h0FFF, 1'b0, 1'b0, "w13_first");
    run_op(13, 16'h0000, 16'h1FFF, 1'b1, 1'b0, "w13_b2b");
    done_low(13, "w13_b2b");

    // Reset in the middle of a RUN, with bit 4 next to be processed
    drive(8, 1'b1, 16'hC3, 16'h3C, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (4) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    check_zero(8, "rst_mid");
    rst8 = 1'b0;
    last_diff[1] = '0;
    last_borr[1] = 1'b0;
    last_ovf[1]  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      sample(8, d, br, ov, bs, dn);
      chk("rst_mid/no_done", 32'(dn), 32'd0);
    end

    // Random regression
    for (int i = 0; i < 500; i++) begin
      run_op(8, 16'($urandom), 16'($urandom), 1'($urandom), (i % 7) == 0, "rnd_w8");
      if ((i % 3) == 0) done_low(8, "rnd_w8");
      run_op(13, 16'($urandom), 16'($urandom), 1'($urandom), (i % 5) == 0, "rnd_w13");
      if ((i % 4) == 0) done_low(13, "rnd_w13");
    end
    for (int i = 0; i < 20; i++) begin
      run_op(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, "rnd_w1");
      if ((i % 2) == 0) done_low(1, "rnd_w1");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
